// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial bit-pattern transmitter with repeat count and inter-repetition gap
//
// Purpose: latches a pattern of up to MAX_LEN bits and shifts it out MSB-first
// (bit len-1 first), one bit per clock, optionally repeated with idle gaps.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active-low
//   start     request transmission (only honoured in IDLE)
//   abort     terminate transmission, return to IDLE
//   pat       pattern bits, bit len-1 sent first
//   len       pattern length, legal 1..MAX_LEN
//   reps      repetition count, legal 1..2^REP_W-1
//   gap       idle cycles between repetitions
//   dout      serial data bit
//   dout_vld  dout carries a pattern bit
//   busy      transmission in progress
//   done      one-cycle pulse after the final bit
//   err       one-cycle pulse when start is rejected
module seq_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               dout,
  output logic               dout_vld,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   bit_idx, bit_idx_nx;
  logic [REP_W-1:0]   rep_left, rep_left_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
  logic [MAX_LEN-1:0] pat_l, pat_l_nx;
  logic [LEN_W-1:0]   len_l, len_l_nx;
  logic [GAP_W-1:0]   gap_l, gap_l_nx;
  logic               dout_nx, dout_vld_nx, busy_nx, done_nx, err_nx;
  logic [REP_W-1:0]   rep_dec;

  // Shift-based selection keeps the index width independent of MAX_LEN.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] idx);
    logic [MAX_LEN-1:0] t;
    t = p >> idx;
    return t[0];
  endfunction

  // bit_idx always names the bit currently on dout; the next-state logic
  // therefore computes the bit for the following cycle.
  always_comb begin
    state_nx    = state;
    bit_idx_nx  = bit_idx;
    rep_left_nx = rep_left;
    gap_cnt_nx  = gap_cnt;
    pat_l_nx    = pat_l;
    len_l_nx    = len_l;
    gap_l_nx    = gap_l;
    dout_nx     = 1'b0;
    dout_vld_nx = 1'b0;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    rep_dec     = rep_left - REP_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0 || len > LEN_W'(MAX_LEN) || reps == '0) begin
            err_nx = 1'b1;
          end else begin
            pat_l_nx    = pat;
            len_l_nx    = len;
            gap_l_nx    = gap;
            rep_left_nx = reps;
            bit_idx_nx  = len - LEN_W'(1);
            state_nx    = SHIFT;
            dout_nx     = bit_at(pat, len - LEN_W'(1));
            dout_vld_nx = 1'b1;
            busy_nx     = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (bit_idx == '0) begin
          rep_left_nx = rep_dec;
          if (rep_dec == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else if (gap_l == '0) begin
            bit_idx_nx  = len_l - LEN_W'(1);
            dout_nx     = bit_at(pat_l, len_l - LEN_W'(1));
            dout_vld_nx = 1'b1;
            busy_nx     = 1'b1;
          end else begin
            state_nx   = GAP;
            gap_cnt_nx = gap_l;
            busy_nx    = 1'b1;
          end
        end else begin
          bit_idx_nx  = bit_idx - LEN_W'(1);
          dout_nx     = bit_at(pat_l, bit_idx - LEN_W'(1));
          dout_vld_nx = 1'b1;
          busy_nx     = 1'b1;
        end
      end

      GAP: begin
        // gap_cnt holds the number of idle cycles still to show, including this one.
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nx    = SHIFT;
          gap_cnt_nx  = '0;
          bit_idx_nx  = len_l - LEN_W'(1);
          dout_nx     = bit_at(pat_l, len_l - LEN_W'(1));
          dout_vld_nx = 1'b1;
          busy_nx     = 1'b1;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
          busy_nx    = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      rep_left <= '0;
      gap_cnt  <= '0;
      pat_l    <= '0;
      len_l    <= '0;
      gap_l    <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_idx  <= bit_idx_nx;
      rep_left <= rep_left_nx;
      gap_cnt  <= gap_cnt_nx;
      pat_l    <= pat_l_nx;
      len_l    <= len_l_nx;
      gap_l    <= gap_l_nx;
      dout     <= dout_nx;
      dout_vld <= dout_vld_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - scoreboard testbench for seq_tx
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic [3:0] gap = '0;
  logic       dout, dout_vld, busy, done, err;

  seq_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat(pat), .len(len), .reps(reps), .gap(gap),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [4:0] bits;   // {dout, dout_vld, busy, done, err}
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;

  // Expected trace notation, one char per cycle starting one cycle after start:
  // '0'/'1' valid bit, '-' gap cycle, 'D' done pulse, 'E' err pulse.
  task automatic push_expect(input int base, input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.cyc = base + 1 + i;
      case (s[i])
        "0": e.bits = 5'b01100;
        "1": e.bits = 5'b11100;
        "-": e.bits = 5'b00100;
        "D": e.bits = 5'b00010;
        default: e.bits = 5'b00001;
      endcase
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle in which the DUT shows any activity consumes one entry.
  always @(negedge clk) begin
    exp_t e;
    if (busy || dout_vld || done || err) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_output cyc=%0d got {dout,vld,busy,done,err}=%b required none",
                 cyc, {dout, dout_vld, busy, done, err});
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.bits != {dout, dout_vld, busy, done, err}) begin
          nmis++;
          $display("FAIL trace cyc=%0d got {dout,vld,busy,done,err}=%b required cyc=%0d bits=%b",
                   cyc, {dout, dout_vld, busy, done, err}, e.cyc, e.bits);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g, input string expect_s);
    push_expect(cyc, expect_s);
    pat = p; len = l; reps = r; gap = g; start = 1'b1;
    step(1);
    start = 1'b0;
    // Scramble the inputs so any use of unlatched values shows up in the trace.
    pat = ~p; len = 4'd7; reps = 4'd5; gap = 4'd1;
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if ({dout, dout_vld, busy, done, err} !== 5'b0) begin
      nmis++;
      $display("FAIL %s got {dout,vld,busy,done,err}=%b required 00000",
               name, {dout, dout_vld, busy, done, err});
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      step(1);
      n++;
    end
    step(2);
    nvec++;
    if (exp_q.size() != 0 || busy) begin
      nmis++;
      $display("FAIL %s_drain got %0d pending entries busy=%b required 0 pending busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    step(3);
    check_zero("reset_state");
    rst = 1'b1;
    step(2);
    check_zero("post_reset_idle");

    send(8'b0000_0101, 4'd3, 4'd1, 4'd0, "101D");
    wait_idle("basic_101");

    send(8'b0000_0010, 4'd4, 4'd2, 4'd2, "0010--0010D");
    wait_idle("gap_0010");

    send(8'b0000_0101, 4'd3, 4'd3, 4'd0, "101101101D");
    wait_idle("back_to_back");

    send(8'h01, 4'd0, 4'd1, 4'd0, "E");
    step(1);
    send(8'h01, 4'd9, 4'd1, 4'd0, "E");
    step(1);
    send(8'h01, 4'd3, 4'd0, 4'd0, "E");
    wait_idle("err_cases");

    // Start while busy is ignored; abort in the fifth bit ends with no done.
    send(8'b0000_1011, 4'd4, 4'd2, 4'd0, "10111");
    step(1);
    pat = 8'hFF; len = 4'd2; reps = 4'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_zero("after_abort");
    wait_idle("abort");

    // A start issued in the done cycle is accepted.
    send(8'b0000_0110, 4'd3, 4'd1, 4'd0, "110D");
    step(3);
    send(8'h01, 4'd1, 4'd2, 4'd1, "1-1D");
    wait_idle("start_in_done");

    // Reset during the gap clears everything on the next cycle.
    send(8'b0000_0010, 4'd2, 4'd2, 4'd3, "10-");
    step(2);
    rst = 1'b0;
    step(1);
    check_zero("reset_in_gap");
    rst = 1'b1;
    step(1);
    send(8'h01, 4'd1, 4'd1, 4'd0, "1D");
    wait_idle("single_bit");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
